// File: rtl/matrix_pkg.sv
// Shared defaults and FSM encoding for the matrix dibit transmitter.
package matrix_pkg;
  localparam int MAX_ELEMENT_SIZE   = 8;
  localparam int MAX_SIZE_A         = 32;
  localparam int MAX_SIZE_B         = 32;
  localparam int DIBITS_PER_ELEMENT = MAX_ELEMENT_SIZE / 2;

  typedef enum logic [1:0] {IDLE, SEND, CKSUM, DONE} tx_state_t;
endpackage

// File: rtl/row_serializer.sv
// Row shift register: emits a packed row MSB-first, one dibit per cycle,
// flagging the last beat and the first beat of each element.
module row_serializer #(
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_load,
  input  logic [ELEM_W*NUM_ELEM-1:0] i_data,
  output logic                       o_vld,
  output logic [1:0]                 o_dibit,
  output logic                       o_last,
  output logic [ELEM_W-1:0]          o_elem,
  output logic                       o_elem_first
);
  import matrix_pkg::*;

  localparam int W     = ELEM_W * NUM_ELEM;
  localparam int DPE   = ELEM_W / 2;
  localparam int BEATS = NUM_ELEM * DPE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = (DPE > 1) ? $clog2(DPE) : 1;

  logic [W-1:0]  r_sr;
  logic [BW-1:0] r_cnt;
  logic [SW-1:0] r_sub;
  logic          r_vld;

  // Shifting zeros in means the register is all-zero once drained, so the
  // dibit output is naturally 0 whenever nothing is valid.
  assign o_vld        = r_vld;
  assign o_dibit      = r_sr[W-1 -: 2];
  assign o_elem       = r_sr[W-1 -: ELEM_W];
  assign o_last       = r_vld && (r_cnt == BW'(BEATS - 1));
  assign o_elem_first = r_vld && (r_sub == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_sub <= '0;
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= '0;
      r_sub <= '0;
      r_vld <= 1'b1;
    end else if (r_vld) begin
      r_sr  <= r_sr << 2;
      r_sub <= (r_sub == SW'(DPE - 1)) ? '0 : r_sub + 1'b1;
      if (o_last) begin
        r_vld <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/matrix_transmitter.sv
// Matrix transmitter: fetches rows on demand and streams them as dibits.
// Define MATRIX_TX_CHECKSUM_EN to append a modulo-2^element checksum.
module matrix_transmitter #(
  parameter int MAX_ELEMENT_SIZE = matrix_pkg::MAX_ELEMENT_SIZE,
  parameter int MAX_SIZE_A       = matrix_pkg::MAX_SIZE_A,
  parameter int MAX_SIZE_B       = matrix_pkg::MAX_SIZE_B
) (
  input  logic                                 eth_refclk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 row_req,
  output logic [$clog2(MAX_SIZE_A)-1:0]        row_addr,
  input  logic                                 row_valid,
  input  logic [MAX_SIZE_B*MAX_ELEMENT_SIZE-1:0] row_data,
  output logic                                 axiov,
  output logic [1:0]                           axiod,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 underrun
);
  import matrix_pkg::*;

  localparam int RW = MAX_SIZE_B * MAX_ELEMENT_SIZE;
  localparam int AW = $clog2(MAX_SIZE_A);
  localparam int CW = $clog2(MAX_SIZE_A + 1);

  tx_state_t             r_state;
  logic                  r_out;
  logic [RW-1:0]         r_hold;
  logic                  r_hold_vld;
  logic [CW-1:0]         r_req_cnt;
  logic [CW-1:0]         r_ld_cnt;

  logic                        w_sr_vld, w_sr_last, w_elem_first;
  logic [1:0]                  w_sr_d;
  logic [MAX_ELEMENT_SIZE-1:0] w_elem;
  logic                        w_accept, w_sr_free, w_ld_new, w_ld_hold, w_ld;
  logic                        w_hold_nxt, w_out_nxt, w_issue, w_row_end;
  logic [RW-1:0]               w_ld_data;
  logic                        w_ck_vld;
  logic [1:0]                  w_ck_d;

  // A row arriving on the shifter's last beat goes straight in, so a
  // just-in-time response never produces a gap.
  assign w_accept   = row_valid && r_out;
  assign w_sr_free  = !w_sr_vld || w_sr_last;
  assign w_ld_new   = w_accept && w_sr_free && !r_hold_vld;
  assign w_ld_hold  = w_sr_last && r_hold_vld;
  assign w_ld       = w_ld_new || w_ld_hold;
  assign w_ld_data  = r_hold_vld ? r_hold : row_data;
  assign w_hold_nxt = r_hold_vld ? !w_sr_last : (w_accept && !w_sr_free);
  assign w_out_nxt  = r_out && !w_accept;
  assign w_issue    = (r_state == SEND) && !w_out_nxt && !w_hold_nxt &&
                      (r_req_cnt < CW'(MAX_SIZE_A));
  assign w_row_end  = w_sr_last && !w_ld;

  row_serializer #(
    .ELEM_W   (MAX_ELEMENT_SIZE),
    .NUM_ELEM (MAX_SIZE_B)
  ) u_ser (
    .clk          (eth_refclk),
    .rst          (rst),
    .i_load       (w_ld),
    .i_data       (w_ld_data),
    .o_vld        (w_sr_vld),
    .o_dibit      (w_sr_d),
    .o_last       (w_sr_last),
    .o_elem       (w_elem),
    .o_elem_first (w_elem_first)
  );

`ifdef MATRIX_TX_CHECKSUM_EN
  localparam int DPE = MAX_ELEMENT_SIZE / 2;
  localparam int KW  = (DPE > 1) ? $clog2(DPE) : 1;
  logic [MAX_ELEMENT_SIZE-1:0] r_acc, r_ck_sr, w_acc_nxt;
  logic [KW-1:0]               r_ck_cnt;
  logic                        r_ck_vld;
  // Each element is counted once, on its first dibit.
  assign w_acc_nxt = r_acc + (w_elem_first ? w_elem : '0);
  assign w_ck_vld  = r_ck_vld;
  assign w_ck_d    = r_ck_sr[MAX_ELEMENT_SIZE-1 -: 2];
`else
  logic w_unused_elem;
  assign w_unused_elem = ^{w_elem, w_elem_first};
  assign w_ck_vld      = 1'b0;
  assign w_ck_d        = 2'b00;
`endif

  assign axiov = w_sr_vld | w_ck_vld;
  assign axiod = w_sr_d | w_ck_d;

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out      <= 1'b0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_req_cnt  <= '0;
      r_ld_cnt   <= '0;
      row_req    <= 1'b0;
      row_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
      r_acc      <= '0;
      r_ck_sr    <= '0;
      r_ck_cnt   <= '0;
      r_ck_vld   <= 1'b0;
`endif
    end else begin
      row_req <= 1'b0;
      done    <= 1'b0;
      if (w_accept) r_out <= 1'b0;
      if (w_ld_hold) begin
        r_hold_vld <= 1'b0;
      end else if (w_accept && !w_sr_free) begin
        r_hold     <= row_data;
        r_hold_vld <= 1'b1;
      end
      if (w_ld) r_ld_cnt <= r_ld_cnt + 1'b1;
      if (w_issue) begin
        row_req   <= 1'b1;
        row_addr  <= r_req_cnt[AW-1:0];
        r_req_cnt <= r_req_cnt + 1'b1;
        r_out     <= 1'b1;
      end
      case (r_state)
        IDLE: if (start) begin
          r_state   <= SEND;
          busy      <= 1'b1;
          underrun  <= 1'b0;
          row_req   <= 1'b1;
          row_addr  <= '0;
          r_req_cnt <= CW'(1);
          r_ld_cnt  <= '0;
          r_out     <= 1'b1;
`ifdef MATRIX_TX_CHECKSUM_EN
          r_acc     <= '0;
`endif
        end
        SEND: begin
`ifdef MATRIX_TX_CHECKSUM_EN
          if (w_elem_first) r_acc <= w_acc_nxt;
`endif
          if (w_row_end) begin
            if (r_ld_cnt == CW'(MAX_SIZE_A)) begin
`ifdef MATRIX_TX_CHECKSUM_EN
              r_state  <= CKSUM;
              r_ck_sr  <= w_acc_nxt;
              r_ck_cnt <= '0;
              r_ck_vld <= 1'b1;
`else
              r_state  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
`endif
            end else begin
              underrun <= 1'b1;
            end
          end
        end
`ifdef MATRIX_TX_CHECKSUM_EN
        CKSUM: begin
          r_ck_sr <= r_ck_sr << 2;
          if (r_ck_cnt == KW'(DPE - 1)) begin
            r_ck_vld <= 1'b0;
            r_state  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            r_ck_cnt <= r_ck_cnt + 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_transmitter.sv
// Randomized bench for matrix_transmitter against a row/element stream model.
module tb_matrix_transmitter;
  import matrix_pkg::*;

  localparam int E   = MAX_ELEMENT_SIZE;
  localparam int A   = MAX_SIZE_A;
  localparam int B   = MAX_SIZE_B;
  localparam int DPE = E / 2;
  localparam int RW  = B * E;
  localparam int AW  = $clog2(A);

  logic          clk = 1'b0;
  logic          rst, start, row_valid;
  logic [RW-1:0] row_data;
  logic          row_req, axiov, busy, done, underrun;
  logic [AW-1:0] row_addr;
  logic [1:0]    axiod;

  always #5 clk = ~clk;

  matrix_transmitter dut (
    .eth_refclk (clk),
    .rst        (rst),
    .start      (start),
    .row_req    (row_req),
    .row_addr   (row_addr),
    .row_valid  (row_valid),
    .row_data   (row_data),
    .axiov      (axiov),
    .axiod      (axiod),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  int          vecs = 0;
  int          miss = 0;
  logic [E-1:0] mat [A][B];
  logic [1:0]  got [$];
  logic [1:0]  exp_q [$];
  int          lat = 2;
  logic        resp_abort = 1'b0;
  int          spur_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vecs++;
    if (obs !== want) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [RW-1:0] pack_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c < B; c++) v[RW-1-c*E -: E] = mat[r][c];
    return v;
  endfunction

  // Expected stream: every element MSB dibit first, then the optional checksum.
  task automatic build_exp();
    logic [E-1:0] sum;
    sum = '0;
    exp_q.delete();
    for (int r = 0; r < A; r++)
      for (int c = 0; c < B; c++) begin
        sum = sum + mat[r][c];
        for (int d = DPE - 1; d >= 0; d--) exp_q.push_back(2'((mat[r][c] >> (2 * d)) & 3));
      end
`ifdef MATRIX_TX_CHECKSUM_EN
    for (int d = DPE - 1; d >= 0; d--) exp_q.push_back(2'((sum >> (2 * d)) & 3));
`endif
  endtask

  // Row memory responder with configurable (or random, lat<0) latency.
  initial begin
    int   a, l, seen;
    bit   ab;
    seen      = 0;
    row_valid = 1'b0;
    row_data  = '0;
    forever begin
      @(negedge clk);
      row_valid = 1'b0;
      if (spur_cnt != seen) begin
        seen++;
        row_valid = 1'b1;
        row_data  = {B{8'($urandom_range(1, 255))}};
      end else if (row_req && !resp_abort) begin
        a  = int'(row_addr);
        l  = (lat < 0) ? int'($urandom_range(1, 40)) : lat;
        ab = 1'b0;
        for (int k = 0; k < l; k++) begin
          @(negedge clk);
          row_valid = 1'b0;
          if (resp_abort) ab = 1'b1;
        end
        if (!ab) begin
          row_valid = 1'b1;
          row_data  = pack_row(a);
        end
      end
    end
  end

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_axiov"}, axiov, 0);
    chk({pfx, "_axiod"}, axiod, 0);
    chk({pfx, "_row_req"}, row_req, 0);
    chk({pfx, "_row_addr"}, row_addr, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_underrun"}, underrun, 0);
  endtask

  task automatic run(input int restart_at, input int rst_at, input bit exp_under, input int exp_gaps);
    int gaps, dones, zbad, busybad, cyc, post, n;
    bit prev_v, fin, restarted;
    gaps = 0; dones = 0; zbad = 0; busybad = 0; cyc = 0; post = 0;
    prev_v = 0; fin = 0; restarted = 0;
    got.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("req_after_start", row_req, 1);
    chk("addr_after_start", row_addr, 0);
    chk("underrun_clr_on_start", underrun, 0);
    while (cyc < 20000 && post < 12) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (axiov) begin
        if (!prev_v && got.size() > 0) gaps++;
        got.push_back(axiod);
      end else if (axiod != 2'b00) zbad++;
      prev_v = axiov;
      if (done) begin
        dones++;
        if (busy) busybad++;
        fin = 1'b1;
      end
      if (fin) post++;
      if (restart_at >= 0 && !restarted && got.size() == restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (rst_at >= 0 && got.size() == rst_at) begin
        rst = 1'b1; resp_abort = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("after_mid_rst");
        repeat (4) @(negedge clk);
        resp_abort = 1'b0;
        return;
      end
    end
    if (!fin) chk("timeout_waiting_done", 0, 1);
    chk("beat_count", got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("beat%0d", i), got[i], exp_q[i]);
    chk("done_pulses", dones, 1);
    chk("busy_during_done", busybad, 0);
    chk("axiod_zero_when_idle", zbad, 0);
    chk("underrun", underrun, exp_under);
    chk("busy_after_done", busy, 0);
    if (exp_gaps >= 0) chk("axiov_gaps", gaps, exp_gaps);
  endtask

  initial begin
    logic [1:0] first8 [8];
    int bad;
    first8 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Counting pattern, fast responder: contiguous stream.
    for (int r = 0; r < A; r++)
      for (int c = 0; c < B; c++) mat[r][c] = E'((r * 32 + c) % 256);
    build_exp();
    lat = 2;
    run(-1, -1, 1'b0, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("pattern_beat%0d", i), got[i], first8[i]);

    // Slow responder: one gap per row boundary, sticky underrun.
    lat = 200;
    run(-1, -1, 1'b1, A - 1);

    // Spurious row_valid in IDLE must not start anything.
    spur_cnt++;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (axiov || busy || row_req) bad++;
    end
    chk("spurious_valid_ignored", bad, 0);
    for (int r = 0; r < A; r++)
      for (int c = 0; c < B; c++) mat[r][c] = E'($urandom);
    build_exp();
    lat = -1;
    run(-1, -1, 1'b0, 0);

    // start re-pulsed mid-transfer is ignored.
    lat = 2;
    run(500, -1, 1'b0, 0);

    // Reset mid-row, then a clean restart with fresh data.
    run(-1, 1000, 1'b0, 0);
    for (int r = 0; r < A; r++)
      for (int c = 0; c < B; c++) mat[r][c] = E'($urandom);
    build_exp();
    lat = -1;
    run(-1, -1, 1'b0, 0);

`ifdef MATRIX_TX_CHECKSUM_EN
    for (int r = 0; r < A; r++)
      for (int c = 0; c < B; c++) mat[r][c] = '0;
    mat[0][0] = E'(8'hA5);
    build_exp();
    lat = 2;
    run(-1, -1, 1'b0, 0);
    chk("cksum_total_beats", got.size(), A * B * DPE + DPE);
    if (got.size() >= 4) begin
      chk("cksum_beat0", got[got.size()-4], 2);
      chk("cksum_beat1", got[got.size()-3], 2);
      chk("cksum_beat2", got[got.size()-2], 1);
      chk("cksum_beat3", got[got.size()-1], 1);
    end else begin
      chk("cksum_beats_present", got.size(), 4);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/matrix_transmitter.md
MATRIX_TRANSMITTER -- requirements
Module: matrix_transmitter

Interface
REQ-001 SHALL have parameter MAX_ELEMENT_SIZE, default 8, bits per element (even only).
REQ-002 SHALL have parameter MAX_SIZE_A, default 32, rows per matrix.
REQ-003 SHALL have parameter MAX_SIZE_B, default 32, elements per row.
REQ-004 SHALL run on one clock and use a synchronous, active-high reset: eth_refclk  input  1  sole clock; rst  input  1  reset.
REQ-005 SHALL have the port start  input  1: one-cycle pulse that starts matrix transmission.
REQ-006 SHALL have the port row_req  output  1: one-cycle request for the row at row_addr.
REQ-007 SHALL have the port row_addr  output  $clog2(MAX_SIZE_A): index of the requested row.
REQ-008 SHALL have the port row_valid  input  1: one-cycle pulse marking row_data valid.
REQ-009 SHALL have the port row_data  input  MAX_SIZE_B*MAX_ELEMENT_SIZE: packed row, element 0 in the MSBs.
REQ-010 SHALL have the port axiov  output  1: dibit valid.
REQ-011 SHALL have the port axiod  output  2: dibit data.
REQ-012 SHALL have the port busy  output  1: high from start acceptance until done.
REQ-013 SHALL have the port done  output  1: one-cycle completion pulse.
REQ-014 SHALL have the port underrun  output  1: sticky, row data arrived late.

Function
REQ-015 SHALL implement states IDLE, SEND, CKSUM and DONE.
REQ-016 IDLE: start SHALL be accepted, busy SHALL rise the next cycle, and row_req with row_addr=0 SHALL pulse the next cycle.
REQ-017 SHALL keep at most one row request outstanding, and SHALL ignore row_valid when no request is outstanding, including in IDLE.
REQ-018 SHALL hold rows in a serializing shift register plus a one-entry holding buffer. When row_valid arrives and the shift register is empty, the row SHALL load the shift register; otherwise it SHALL load the holding buffer.
REQ-019 SHALL issue a request for row r+1 (r+1 < MAX_SIZE_A) on the cycle after row r is accepted, provided the holding buffer is empty.
REQ-020 SHALL assert axiov the cycle after row_valid loads an empty shift register, and SHALL then emit one dibit per cycle.
REQ-021 SHALL send elements in index order, each element MSB dibit first, giving MAX_ELEMENT_SIZE/2 beats per element.
REQ-022 On the last dibit of a row with the holding buffer full, the buffer SHALL transfer into the shift register with no gap in axiov.
REQ-023 On the last dibit of a row with the holding buffer empty and rows remaining, axiov SHALL be 0 until data arrives, and underrun SHALL be set.
REQ-024 After the last dibit of row MAX_SIZE_A-1, the block SHALL go to CKSUM if enabled, otherwise to DONE.
REQ-025 DONE: done SHALL be 1 and busy SHALL be 0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-026 Total beats without underrun SHALL be MAX_SIZE_A*MAX_SIZE_B*MAX_ELEMENT_SIZE/2, i.e. 4096 by default.
REQ-027 start while busy SHALL be ignored; underrun SHALL clear on an accepted start.
REQ-028 axiod SHALL be 0 whenever axiov is 0.

Reset
REQ-029 rst SHALL be synchronous, active-high and effective from any state, including mid-row.
REQ-030 On rst: axiov, axiod, row_req, row_addr, busy, done and underrun SHALL be 0; state SHALL be IDLE; both buffers SHALL be empty; any outstanding request SHALL be dropped.

Configuration
REQ-031 With macro MATRIX_TX_CHECKSUM_EN defined: CKSUM SHALL emit MAX_ELEMENT_SIZE/2 beats of the modulo-2^MAX_ELEMENT_SIZE sum of all transmitted elements, MSB dibit first, contiguous with the last data beat.
REQ-032 With MATRIX_TX_CHECKSUM_EN undefined: no accumulator or CKSUM logic SHALL exist, and the last data beat SHALL go directly to DONE.

Structure
REQ-033 Package matrix_pkg SHALL hold the MAX_ELEMENT_SIZE/MAX_SIZE_A/MAX_SIZE_B defaults, the DIBITS_PER_ELEMENT constant and the tx_state_t enum.
REQ-034 SHALL instantiate one sub-module, row_serializer: shift register, beat counter, load and last-beat signalling.

Verification
REQ-035 Element (r,c)=(r*32+c)%256, responder latency 2: 4096 contiguous beats, beats 0-3 = 0,0,0,0, beats 4-7 = 0,0,0,1, one done pulse, underrun=0.
REQ-036 Responder latency 200 cycles: axiov gaps between rows, underrun=1, data sequence identical to REQ-035.
REQ-037 start re-pulsed at beat 500: ignored, exactly 4096 beats, one done.
REQ-038 rst at beat 1000: all outputs 0 on the next cycle; a new start re-requests row_addr=0.
REQ-039 Spurious row_valid in IDLE: no axiov; the subsequent transfer is correct.
REQ-040 With MATRIX_TX_CHECKSUM_EN, element (0,0)=0xA5 and all others 0: 4100 beats, final four beats = 2,2,1,1.
